// File: rtl/bf_scan_sequencer_if.sv
// Control and handshake bundle between the frame scan sequencer (master)
// and the delay controller / summation unit / downstream sink (slave).
interface bf_scan_sequencer_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int X_WIDTH      = 6,
  parameter int Z_WIDTH      = 8
);
  logic                    frame_start;
  logic                    frame_abort;
  logic                    dc_start;
  logic [X_WIDTH-1:0]      x_f;
  logic [Z_WIDTH-1:0]      z_f;
  logic                    dc_ready;
  logic [NUM_CHANNELS-1:0] valid_b;
  logic                    sum_en;
  logic                    start_sum;
  logic                    sum_valid;
  logic                    out_valid;
  logic                    out_ready;
  logic [X_WIDTH-1:0]      out_x;
  logic [Z_WIDTH-1:0]      out_z;
  logic                    busy;
  logic                    line_done;
  logic                    frame_done;
  logic                    timeout_err;

  modport master (
    input  frame_start, frame_abort, dc_ready, valid_b, sum_valid, out_ready,
    output dc_start, x_f, z_f, sum_en, start_sum, out_valid, out_x, out_z,
           busy, line_done, frame_done, timeout_err
  );

  modport slave (
    output frame_start, frame_abort, dc_ready, valid_b, sum_valid, out_ready,
    input  dc_start, x_f, z_f, sum_en, start_sum, out_valid, out_x, out_z,
           busy, line_done, frame_done, timeout_err
  );
endinterface

// File: rtl/bf_scan_sequencer.sv
// Frame scan sequencer for the delay-and-sum beamformer: walks focal points
// in raster order (z fastest) and hands each summed sample downstream.
module bf_scan_sequencer #(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_X        = 64,
  parameter int NUM_Z        = 256,
  parameter int X_WIDTH      = 6,
  parameter int Z_WIDTH      = 8,
  parameter int TIMEOUT      = 1023
) (
  input  logic                clk,
  input  logic                reset,
  bf_scan_sequencer_if.master bus
);
  localparam int                   CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [X_WIDTH-1:0]   X_LAST    = X_WIDTH'(NUM_X - 1);
  localparam logic [Z_WIDTH-1:0]   Z_LAST    = Z_WIDTH'(NUM_Z - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DELAY,
    SUM_WAIT,
    EMIT
  } state_e;

  state_e                state_q, state_d;
  logic [X_WIDTH-1:0]    x_f_q, x_f_d;
  logic [Z_WIDTH-1:0]    z_f_q, z_f_d;
  logic [X_WIDTH-1:0]    out_x_q, out_x_d;
  logic [Z_WIDTH-1:0]    out_z_q, out_z_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  started_q, started_d;
  logic [CNT_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [NUM_CHANNELS-1:0] valid_all;
  logic abort;
  logic dc_start;
  logic sum_en;
  logic start_sum;
  logic sum_hit;
  logic accept;
  logic tmo_hit;
  logic last_z;
  logic last_x;

  assign valid_all = bus.valid_b;
  assign abort     = bus.frame_abort;
  assign last_z    = (z_f_q == Z_LAST);
  assign last_x    = (x_f_q == X_LAST);
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

  // Pulses decode the registered state with the same-cycle inputs so that
  // start_sum lands in the first all-ones valid_b cycle, and an abort in the
  // same cycle can still suppress them.
  assign dc_start  = (state_q == LOAD) && !abort;
  assign sum_en    = (state_q == WAIT_DELAY) && bus.dc_ready && !abort;
  assign start_sum = (state_q == SUM_WAIT) && !started_q && (&valid_all) && !abort;
  assign sum_hit   = (state_q == SUM_WAIT) && bus.sum_valid && (started_q || start_sum) && !abort;
  assign accept    = (state_q == EMIT) && bus.out_ready && !abort;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave one
    // unassigned and infer a latch.
    state_d       = state_q;
    x_f_d         = x_f_q;
    z_f_d         = z_f_q;
    out_x_d       = out_x_q;
    out_z_d       = out_z_q;
    timeout_err_d = timeout_err_q;
    started_d     = started_q | start_sum;
    tmo_cnt_d     = tmo_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d       = LOAD;
          x_f_d         = '0;
          z_f_d         = '0;
          timeout_err_d = 1'b0;
        end
      end
      LOAD: begin
        state_d   = WAIT_DELAY;
        tmo_cnt_d = '0;
      end
      WAIT_DELAY: begin
        if (bus.dc_ready) begin
          state_d   = SUM_WAIT;
          tmo_cnt_d = '0;
          started_d = 1'b0;
        end else if (tmo_hit) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end
      end
      SUM_WAIT: begin
        if (sum_hit) begin
          state_d = EMIT;
          out_x_d = x_f_q;
          out_z_d = z_f_q;
        end else if (tmo_hit) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end
      end
      EMIT: begin
        if (accept) begin
          state_d = LOAD;
          if (last_z) begin
            z_f_d = '0;
            if (last_x) begin
              x_f_d   = '0;
              state_d = IDLE;
            end else begin
              x_f_d = x_f_q + 1'b1;
            end
          end else begin
            z_f_d = z_f_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything: back to IDLE with the scan position frozen.
    if (abort) begin
      state_d       = IDLE;
      x_f_d         = x_f_q;
      z_f_d         = z_f_q;
      out_x_d       = out_x_q;
      out_z_d       = out_z_q;
      timeout_err_d = timeout_err_q;
    end

    out_valid_d = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      x_f_q         <= '0;
      z_f_q         <= '0;
      out_x_q       <= '0;
      out_z_q       <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      started_q     <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      x_f_q         <= x_f_d;
      z_f_q         <= z_f_d;
      out_x_q       <= out_x_d;
      out_z_q       <= out_z_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      started_q     <= started_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign bus.dc_start    = dc_start;
  assign bus.x_f         = x_f_q;
  assign bus.z_f         = z_f_q;
  assign bus.sum_en      = sum_en;
  assign bus.start_sum   = start_sum;
  assign bus.out_valid   = out_valid_q && !abort;
  assign bus.out_x       = out_x_q;
  assign bus.out_z       = out_z_q;
  assign bus.busy        = busy_q;
  assign bus.line_done   = accept && last_z;
  assign bus.frame_done  = accept && last_z && last_x;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_bf_scan_sequencer.sv
// Self-checking bench for bf_scan_sequencer on a 2x3 frame with TIMEOUT=8;
// the bench plays delay controller, summation unit and downstream sink.
module tb_bf_scan_sequencer;
  localparam int NCH = 16;
  localparam int NX  = 2;
  localparam int NZ  = 3;
  localparam int XW  = 1;
  localparam int ZW  = 2;
  localparam int TMO = 8;
  localparam int LW  = 5 + XW + ZW;
  localparam int EW  = 6 + XW + ZW;
  localparam int ZRW = 8 + 2 * (XW + ZW);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bf_scan_sequencer_if #(.NUM_CHANNELS(NCH), .X_WIDTH(XW), .Z_WIDTH(ZW)) bus ();

  bf_scan_sequencer #(
    .NUM_CHANNELS(NCH), .NUM_X(NX), .NUM_Z(NZ),
    .X_WIDTH(XW), .Z_WIDTH(ZW), .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc, n_line, n_frame;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic fs, input logic fa, input logic dr,
                       input logic [NCH-1:0] vb, input logic sv, input logic ordy);
    bus.frame_start = fs;
    bus.frame_abort = fa;
    bus.dc_ready    = dr;
    bus.valid_b     = vb;
    bus.sum_valid   = sv;
    bus.out_ready   = ordy;
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [NCH-1:0] rand_vb();
    return NCH'($urandom);
  endfunction

  function automatic logic [NCH-1:0] partial_vb();
    logic [NCH-1:0] v;
    v = NCH'($urandom);
    v[$urandom_range(NCH - 1, 0)] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] pulses();
    return {bus.dc_start, bus.sum_en, bus.start_sum, bus.out_valid};
  endfunction

  function automatic logic [ZRW-1:0] all_outs();
    return {bus.busy, pulses(), bus.line_done, bus.frame_done, bus.timeout_err,
            bus.x_f, bus.z_f, bus.out_x, bus.out_z};
  endfunction

  // LOAD cycle, then dc_ready raised dc_lat cycles after dc_start.
  task automatic load_stage(input int ex, input int ez, input int dc_lat);
    logic [LW-1:0] got, want;
    next_cycle(); drive(noise(), 0, 0, rand_vb(), 0, 0); settle();
    got  = {pulses(), bus.busy, bus.x_f, bus.z_f};
    want = {4'b1000, 1'b1, XW'(ex), ZW'(ez)};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL load(%0d,%0d): got %b want %b", ex, ez, got, want);
    end
    for (int i = 1; i < dc_lat; i++) begin
      next_cycle(); drive(noise(), 0, 0, rand_vb(), 0, 0); settle();
      n_cmp++;
      if (pulses() !== 4'b0000) begin
        n_bad++; $display("FAIL wait_delay(%0d,%0d): pulses %b want 0000", ex, ez, pulses());
      end
    end
    next_cycle(); drive(noise(), 0, 1, rand_vb(), 0, 0); settle();
    n_cmp++;
    if (pulses() !== 4'b0100) begin
      n_bad++; $display("FAIL sum_en(%0d,%0d): pulses %b want 0100", ex, ez, pulses());
    end
  endtask

  // pv partial valid_b cycles, one all-ones cycle, sum_valid slat cycles after it.
  task automatic sum_stage(input int pv, input logic directed, input int slat);
    for (int i = 0; i < pv; i++) begin
      next_cycle(); drive(noise(), 0, 0, directed ? 16'hFFFE : partial_vb(), 0, 0); settle();
      n_cmp++;
      if (pulses() !== 4'b0000) begin
        n_bad++; $display("FAIL partial_valid: pulses %b want 0000", pulses());
      end
    end
    next_cycle(); drive(noise(), 0, 0, '1, slat == 0, 0); settle();
    n_cmp++;
    if (pulses() !== 4'b0010) begin
      n_bad++; $display("FAIL start_sum: pulses %b want 0010", pulses());
    end
    for (int i = 1; i <= slat; i++) begin
      next_cycle(); drive(noise(), 0, 0, rand_vb(), i == slat, 0); settle();
      n_cmp++;
      if (pulses() !== 4'b0000) begin
        n_bad++; $display("FAIL start_sum_once: pulses %b want 0000", pulses());
      end
    end
  endtask

  // stall cycles with out_ready low, then acceptance.
  task automatic emit_stage(input int ex, input int ez, input int stall,
                            input logic ld, input logic fd);
    logic [EW-1:0] got, want;
    for (int i = 0; i < stall; i++) begin
      next_cycle(); drive(noise(), 0, 0, rand_vb(), 0, 0); settle();
      got  = {pulses(), bus.out_x, bus.out_z, bus.line_done, bus.frame_done};
      want = {4'b0001, XW'(ex), ZW'(ez), 2'b00};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL stall(%0d,%0d): got %b want %b", ex, ez, got, want);
      end
    end
    next_cycle(); drive(noise(), 0, 0, rand_vb(), 0, 1); settle();
    got  = {pulses(), bus.out_x, bus.out_z, bus.line_done, bus.frame_done};
    want = {4'b0001, XW'(ex), ZW'(ez), ld, fd};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL accept(%0d,%0d): got %b want %b", ex, ez, got, want);
    end
    n_acc++;
    n_line  += int'(bus.line_done);
    n_frame += int'(bus.frame_done);
  endtask

  task automatic start_frame();
    next_cycle(); drive(1, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({bus.busy, bus.dc_start} !== 2'b00) begin
      n_bad++; $display("FAIL frame_start_idle: busy,dc_start %b want 00", {bus.busy, bus.dc_start});
    end
  endtask

  // mode 0 plain, 1 backpressure at (0,1), 2 partial valid_b at (0,0), 3 random.
  task automatic do_frame(input int mode);
    int dc_lat, pv, slat, stall;
    logic dir;
    n_acc = 0; n_line = 0; n_frame = 0;
    start_frame();
    for (int x = 0; x < NX; x++) begin
      for (int z = 0; z < NZ; z++) begin
        dc_lat = 2; pv = 0; slat = 1; stall = 0; dir = 1'b0;
        if (mode == 1 && x == 0 && z == 1) stall = 5;
        if (mode == 2 && x == 0 && z == 0) begin pv = 4; dir = 1'b1; end
        if (mode == 3) begin
          dc_lat = $urandom_range(1, 4);
          pv     = $urandom_range(0, 3);
          slat   = $urandom_range(0, 3);
          stall  = $urandom_range(0, 3);
        end
        load_stage(x, z, dc_lat);
        sum_stage(pv, dir, slat);
        emit_stage(x, z, stall, z == NZ - 1, (z == NZ - 1) && (x == NX - 1));
      end
    end
    next_cycle(); drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({bus.busy, pulses()} !== 5'b00000) begin
      n_bad++; $display("FAIL frame_end_idle: busy,pulses %b want 00000", {bus.busy, pulses()});
    end
    n_cmp++;
    if (n_acc !== NX * NZ || n_line !== NX || n_frame !== 1) begin
      n_bad++;
      $display("FAIL frame_counts(mode %0d): samples %0d lines %0d frames %0d want %0d %0d 1",
               mode, n_acc, n_line, n_frame, NX * NZ, NX);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, '0, 0, 0);
    repeat (3) next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle(); drive(0, 0, 0, rand_vb(), noise(), noise()); settle();
      n_cmp++;
      if (all_outs() !== '0) begin
        n_bad++; $display("FAIL reset_idle: outputs %b want all zero", all_outs());
      end
    end
  endtask

  task automatic test_start_abort_idle();
    next_cycle(); drive(1, 1, 0, rand_vb(), 0, 0); settle();
    next_cycle(); drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({bus.busy, pulses()} !== 5'b00000) begin
      n_bad++; $display("FAIL start_with_abort: busy,pulses %b want 00000", {bus.busy, pulses()});
    end
  endtask

  task automatic test_timeout();
    start_frame();
    next_cycle(); drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({pulses(), bus.timeout_err} !== 5'b10000) begin
      n_bad++; $display("FAIL tmo_load: got %b want 10000", {pulses(), bus.timeout_err});
    end
    for (int i = 0; i < TMO; i++) begin
      next_cycle(); drive(noise(), 0, 0, rand_vb(), 0, 0); settle();
      n_cmp++;
      if ({bus.busy, bus.timeout_err, pulses()} !== 6'b100000) begin
        n_bad++; $display("FAIL tmo_wait[%0d]: got %b want 100000", i, {bus.busy, bus.timeout_err, pulses()});
      end
    end
    next_cycle(); drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({bus.busy, bus.timeout_err, pulses()} !== 6'b010000) begin
      n_bad++; $display("FAIL tmo_fire: got %b want 010000", {bus.busy, bus.timeout_err, pulses()});
    end
    next_cycle(); drive(1, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if (bus.timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_sticky: got %b want 1", bus.timeout_err);
    end
    next_cycle(); drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({bus.dc_start, bus.timeout_err} !== 2'b10) begin
      n_bad++; $display("FAIL tmo_clear: dc_start,err %b want 10", {bus.dc_start, bus.timeout_err});
    end
    next_cycle(); drive(0, 1, 0, rand_vb(), 0, 0); settle();
    next_cycle(); drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if ({bus.busy, bus.timeout_err} !== 2'b00) begin
      n_bad++; $display("FAIL tmo_abort_idle: busy,err %b want 00", {bus.busy, bus.timeout_err});
    end
  endtask

  task automatic test_abort();
    logic [4+1+XW+ZW-1:0] got, want;
    start_frame();
    for (int z = 0; z < NZ; z++) begin
      load_stage(0, z, 2);
      sum_stage(0, 1'b0, 1);
      emit_stage(0, z, 0, z == NZ - 1, 1'b0);
    end
    load_stage(1, 0, 2);
    next_cycle(); drive(0, 1, 0, '1, 1, 0); settle();
    n_cmp++;
    if (pulses() !== 4'b0000) begin
      n_bad++; $display("FAIL abort_suppress: pulses %b want 0000", pulses());
    end
    next_cycle(); drive(0, 0, 0, '1, 1, 1); settle();
    got  = {bus.busy, pulses(), bus.x_f, bus.z_f};
    want = {1'b0, 4'b0000, XW'(1), ZW'(0)};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL abort_idle: got %b want %b", got, want);
    end
    do_frame(0);
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    load_stage(0, 0, 2);
    sum_stage(0, 1'b0, 1);
    emit_stage(0, 0, 0, 1'b0, 1'b0);
    load_stage(0, 1, 1);
    sum_stage(0, 1'b0, 0);
    next_cycle(); reset = 1'b1; drive(0, 0, 0, '0, 0, 0); settle();
    n_cmp++;
    if ({bus.out_valid, bus.out_z} !== {1'b1, ZW'(1)}) begin
      n_bad++; $display("FAIL pre_reset_emit: out_valid,out_z %b", {bus.out_valid, bus.out_z});
    end
    next_cycle(); reset = 1'b0; drive(0, 0, 0, rand_vb(), 0, 0); settle();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL reset_mid_frame: outputs %b want all zero", all_outs());
    end
  endtask

  task automatic test_back_to_back_random();
    for (int f = 0; f < 6; f++) do_frame(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    do_frame(0);
    do_frame(1);
    do_frame(2);
    test_start_abort_idle();
    test_timeout();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
